// File: rtl/jk_sched_pkg.sv
// Shared encodings for the JK bank scheduler: bit-command opcodes and controller states.
package jk_sched_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    ACK   = 2'b10
  } state_e;

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit built on an SR register; s and r are derived from j, k and the
// current state, so they can never both be high.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic s;
  logic r;

  assign s = j & ~q;
  assign r = k & q;

  always_ff @(posedge clk) begin
    if (rst)    q <= 1'b0;
    else if (s) q <= 1'b1;
    else if (r) q <= 1'b0;
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_bank_scheduler.sv
// Two-requester round-robin command controller for a bank of JK cells; each accepted
// command drives J/K for exactly one clock edge (IDLE -> DRIVE -> ACK).
module jk_bank_scheduler
  import jk_sched_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [N_BITS-1:0] req0_mask,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [N_BITS-1:0] req1_mask,
  output logic              req1_ready,
  output logic [N_BITS-1:0] q,
  output logic [N_BITS-1:0] qbar,
  output logic              busy,
  output logic              done,
  output logic              done_id
);

  state_e            state;
  state_e            state_next;
  logic              last_grant;
  op_e               op_r;
  logic [N_BITS-1:0] mask_r;
  logic              id_r;
  logic              xfer;
  logic [N_BITS-1:0] j;
  logic [N_BITS-1:0] k;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        if (last_grant) req0_ready = 1'b1;
        else            req1_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  assign xfer = req0_ready | req1_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = DRIVE;
      DRIVE:   state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_r       <= OP_HOLD;
      mask_r     <= '0;
      id_r       <= 1'b0;
    end else begin
      state <= state_next;
      if (xfer) begin
        last_grant <= req1_ready;
        id_r       <= req1_ready;
        op_r       <= req1_ready ? op_e'(req1_op) : op_e'(req0_op);
        mask_r     <= req1_ready ? req1_mask : req0_mask;
      end
    end
  end

  // J/K are only non-zero for the single DRIVE cycle; everywhere else the bank holds.
  always_comb begin
    j = '0;
    k = '0;
    if (state == DRIVE) begin
      case (op_r)
        OP_SET:    j = mask_r;
        OP_RESET:  k = mask_r;
        OP_TOGGLE: begin
          j = mask_r;
          k = mask_r;
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .j    (j[i]),
      .k    (k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  assign busy    = (state != IDLE);
  assign done    = (state == ACK);
  assign done_id = done & id_r;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Directed self-checking bench for jk_bank_scheduler: one task per scenario, inputs
// driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_jk_bank_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid;
  logic [1:0] req0_op;
  logic [7:0] req0_mask;
  logic       req0_ready;
  logic       req1_valid;
  logic [1:0] req1_op;
  logic [7:0] req1_mask;
  logic       req1_ready;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       busy;
  logic       done;
  logic       done_id;

  int checks = 0;
  int errors = 0;

  jk_bank_scheduler #(.N_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_mask  (req0_mask),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_mask  (req1_mask),
    .req1_ready (req1_ready),
    .q          (q),
    .qbar       (qbar),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    assert (!(req0_ready && req1_ready)) else $error("[TB] both ready outputs high");
    assert (qbar === ~q) else $error("[TB] qbar is not the complement of q");
    assert (((dut.j & ~q) & (dut.k & q)) == 8'h00) else $error("[TB] s and r both high on a cell");
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [1:0] op, input logic [7:0] mask);
    req0_valid = v;
    req0_op    = op;
    req0_mask  = mask;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic [7:0] mask);
    req1_valid = v;
    req1_op    = op;
    req1_mask  = mask;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive0(1'b0, 2'b00, 8'h00);
    drive1(1'b0, 2'b00, 8'h00);
    step();
    step();
    @(negedge clk);
    checks++; if (q !== 8'h00) begin errors++; $display("[TB] FAIL reset_q got %h exp 00", q); end
    checks++; if (qbar !== 8'hFF) begin errors++; $display("[TB] FAIL reset_qbar got %h exp ff", qbar); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0 || done_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b/%b exp 0/0", done, done_id); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_set();
    drive0(1'b1, 2'b10, 8'hA5);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL set_ready got %b%b exp 10", req0_ready, req1_ready); end
    step();
    drive0(1'b0, 2'b00, 8'h00);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL set_drive busy/done got %b/%b exp 1/0", busy, done); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL set_busy_ready got %b exp 0", req0_ready); end
    step();
    @(negedge clk);
    checks++; if (done !== 1'b1 || done_id !== 1'b0) begin errors++; $display("[TB] FAIL set_done got %b/%b exp 1/0", done, done_id); end
    checks++; if (q !== 8'hA5) begin errors++; $display("[TB] FAIL set_q got %h exp a5", q); end
    step();
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL set_idle busy/done got %b/%b exp 0/0", busy, done); end
    step();
  endtask

  task automatic test_toggle();
    drive1(1'b1, 2'b11, 8'hFF);
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL tog_ready got %b%b exp 01", req0_ready, req1_ready); end
    step();
    drive1(1'b0, 2'b00, 8'h00);
    step();
    @(negedge clk);
    checks++; if (done !== 1'b1 || done_id !== 1'b1) begin errors++; $display("[TB] FAIL tog_done got %b/%b exp 1/1", done, done_id); end
    checks++; if (q !== 8'h5A || qbar !== 8'hA5) begin errors++; $display("[TB] FAIL tog_q got %h/%h exp 5a/a5", q, qbar); end
    step();
    step();
  endtask

  task automatic test_contention();
    drive0(1'b1, 2'b01, 8'h0F);
    drive1(1'b1, 2'b10, 8'hF0);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL arb_first got %b%b exp 10", req0_ready, req1_ready); end
    step();
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL arb_drive ready %b%b busy %b exp 00 1", req0_ready, req1_ready, busy); end
    step();
    @(negedge clk);
    checks++; if (done !== 1'b1 || done_id !== 1'b0 || q !== 8'h50) begin errors++; $display("[TB] FAIL arb_done0 got %b/%b q=%h exp 1/0 q=50", done, done_id, q); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL arb_ack_ready got %b%b exp 00", req0_ready, req1_ready); end
    step();
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL arb_second got %b%b exp 01", req0_ready, req1_ready); end
    step();
    drive0(1'b0, 2'b00, 8'h00);
    drive1(1'b0, 2'b00, 8'h00);
    step();
    @(negedge clk);
    checks++; if (done !== 1'b1 || done_id !== 1'b1 || q !== 8'hF0) begin errors++; $display("[TB] FAIL arb_done1 got %b/%b q=%h exp 1/1 q=f0", done, done_id, q); end
    step();
    step();
  endtask

  task automatic test_hold_nomask();
    int busy_cnt;
    busy_cnt = 0;
    drive0(1'b1, 2'b00, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (c == 0) begin
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_ready got %b exp 1", req0_ready); end
      end
      if (c == 2) begin
        checks++; if (done !== 1'b1 || done_id !== 1'b0 || q !== 8'hF0) begin errors++; $display("[TB] FAIL hold_done got %b/%b q=%h exp 1/0 q=f0", done, done_id, q); end
      end
      step();
      if (c == 0) drive0(1'b0, 2'b00, 8'h00);
    end
    checks++; if (busy_cnt != 2) begin errors++; $display("[TB] FAIL hold_busy_cycles got %0d exp 2", busy_cnt); end
    busy_cnt = 0;
    drive1(1'b1, 2'b11, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (c == 2) begin
        checks++; if (done !== 1'b1 || done_id !== 1'b1 || q !== 8'hF0) begin errors++; $display("[TB] FAIL nomask_done got %b/%b q=%h exp 1/1 q=f0", done, done_id, q); end
      end
      step();
      if (c == 0) drive1(1'b0, 2'b00, 8'h00);
    end
    checks++; if (busy_cnt != 2) begin errors++; $display("[TB] FAIL nomask_busy_cycles got %0d exp 2", busy_cnt); end
  endtask

  task automatic test_reset_midway();
    drive1(1'b1, 2'b10, 8'h0F);
    step();
    drive1(1'b0, 2'b00, 8'h00);
    step();
    @(negedge clk);
    checks++; if (q !== 8'hFF) begin errors++; $display("[TB] FAIL rstmid_setup_q got %h exp ff", q); end
    step();
    drive0(1'b1, 2'b11, 8'hFF);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_accept got %b exp 1", req0_ready); end
    step();
    drive0(1'b0, 2'b00, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_drive_busy got %b exp 1", busy); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (q !== 8'h00 || qbar !== 8'hFF) begin errors++; $display("[TB] FAIL rstmid_q got %h/%h exp 00/ff", q, qbar); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_state busy/done got %b/%b exp 0/0", busy, done); end
    drive0(1'b1, 2'b10, 8'h3C);
    drive1(1'b1, 2'b10, 8'hC3);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_regrant got %b%b exp 10", req0_ready, req1_ready); end
    step();
    drive0(1'b0, 2'b00, 8'h00);
    drive1(1'b0, 2'b00, 8'h00);
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_done got %b exp 0", done); end
    step();
    @(negedge clk);
    checks++; if (done !== 1'b1 || done_id !== 1'b0 || q !== 8'h3C) begin errors++; $display("[TB] FAIL rstmid_new_done got %b/%b q=%h exp 1/0 q=3c", done, done_id, q); end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    drive1(1'b1, 2'b11, 8'h01);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (req1_ready !== (c % 3 == 0) || req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready cycle %0d got %b%b exp 0%b", c, req0_ready, req1_ready, (c % 3 == 0)); end
      checks++; if (done !== (c % 3 == 2)) begin errors++; $display("[TB] FAIL b2b_done cycle %0d got %b exp %b", c, done, (c % 3 == 2)); end
      if (c % 3 == 2) begin
        exp_q = ((c / 3) % 2 == 0) ? 8'h3D : 8'h3C;
        checks++; if (done_id !== 1'b1 || q !== exp_q) begin errors++; $display("[TB] FAIL b2b_result cycle %0d got id=%b q=%h exp id=1 q=%h", c, done_id, q, exp_q); end
      end
      step();
      if (c == 9) drive1(1'b0, 2'b00, 8'h00);
    end
  endtask

  initial begin
    $display("[TB] starting jk_bank_scheduler bench");
    test_reset();
    test_set();
    test_toggle();
    test_contention();
    test_hold_nomask();
    test_reset_midway();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_scheduler.md
# jk_bank_scheduler

Command controller for a bank of JK flip-flop cells, each built from an SR flip-flop. Two requesters issue masked bit commands (hold, reset, set, toggle) through a valid/ready handshake. A round-robin arbiter picks a winner, and a small FSM drives the J/K inputs for exactly one clock edge. The bank never sees S=R=1, which keeps the SR core out of its undefined state.

## Interface
Parameters:
- N_BITS, 8, width of the flip-flop bank.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a command.
- req0_op  in  2  requester 0 operation: 00 hold, 01 reset, 10 set, 11 toggle.
- req0_mask  in  N_BITS  requester 0 bit select; 1 = bit affected.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req1_valid, req1_op, req1_mask, req1_ready  same as requester 0, for requester 1.
- q  out  N_BITS  bank state.
- qbar  out  N_BITS  always ~q.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse: command applied, q already updated.
- done_id  out  1  requester whose command completed; valid only while done=1.

## Operation
- FSM states: IDLE, DRIVE, ACK.
  - IDLE→DRIVE on handshake.
  - DRIVE→ACK unconditionally.
  - ACK→IDLE unconditionally.
- Handshake: reqX_ready is combinational and asserts only in IDLE for the arbiter winner. A transfer occurs when valid and ready are both 1. On transfer, latch op, mask and requester id.
- Arbitration is round-robin on a last_grant register, reset value 1, so requester 0 wins the first contention.
  - Only one valid: it wins.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant updates on every transfer.
  - Ready is never asserted to both requesters in the same cycle.
- J/K generation per bit i, in DRIVE only:
  - j[i] = mask[i] & (op==set | op==toggle)
  - k[i] = mask[i] & (op==reset | op==toggle)
  - Outside DRIVE, j = k = 0 (hold).
- Cell behaviour:
  - s = j & ~q, r = k & q, so s & r == 0 by construction.
  - Toggle inverts the bit; hold keeps it.
- A hold op, or mask = 0, still runs the full IDLE→DRIVE→ACK sequence and pulses done, with q unchanged.
- Requesters must keep valid, op and mask stable until ready. A request deasserted before ready is simply not served; there is no error path.

## Timing
- Reset values: q=0, qbar=all ones, busy=0, done=0, done_id=0, both ready=0, state IDLE, last_grant=1.
- Reset during DRIVE or ACK:
  - Returns to IDLE and clears q.
  - No done pulse; the in-flight command is dropped.
  - rst has priority over every other event in the same cycle.
- Latency, with the handshake in cycle t:
  - t+1: state DRIVE, busy=1.
  - Rising edge ending t+1: q updates.
  - t+2: state ACK, done=1, done_id valid, new q visible.
  - t+3: IDLE; earliest next handshake.
- Throughput: one command per 3 cycles.
- While busy=1, both ready outputs are 0. A requester held pending during ACK is considered in the t+3 IDLE cycle.

## Structure
- Package jk_sched_pkg holds:
  - the op encoding enum (OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE);
  - the FSM state enum (IDLE, DRIVE, ACK).
- Sub-module jk_cell: one bit, containing an SR register with synchronous active-high reset plus the s/r derivation from j, k and q.
  - Instantiate N_BITS copies in a generate loop.
  - The top level holds only the arbiter, the FSM and the J/K decode.
- Bench assertions:
  - never (s & r) on any cell;
  - never both ready outputs high;
  - qbar == ~q at all times.

## Test plan
- Reset, then req0 set with mask 8'hA5 → req0_ready in the accept cycle; done=1 with done_id=0 two cycles later; q=8'hA5.
- From q=8'hA5, req1 toggle with mask 8'hFF → q=8'h5A at done; qbar=8'hA5.
- From q=8'h5A, req0 and req1 held valid continuously, req0 reset with mask 8'h0F, req1 set with mask 8'hF0:
  - req0 granted first (last_grant=1): done, done_id=0, q=8'h50;
  - req1 granted at the next IDLE: done, done_id=1, q=8'hF0;
  - the ready pulses are 3 cycles apart.
- Hold op, then toggle with mask 0 → each gives a done pulse; q unchanged; busy high exactly 2 cycles per command.
- From q=8'hFF, toggle accepted, then rst=1 in the DRIVE cycle → next cycle q=0, busy=0, no done pulse; a new request is accepted in the first IDLE cycle after rst drops.
- req1 alone valid for 4 consecutive commands → every command granted to req1 with no idle bubbles beyond the 3-cycle cadence.
